// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and register-index constants for the dual-issue hazard unit.
package hazard_pkg;
    typedef enum logic {
        PAIR = 1'b0,
        HALF = 1'b1
    } state_t;
    localparam int REG_W_DEF = 5;
    localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: flags a load-use hit of one ID slot against one EX slot.
//   ex_dest_i / ex_ld_i : EX-slot destination and load flag
//   rs_i / rt_i         : ID-slot sources; rt_i counts only when usesrt_i is set
//   hit_o               : EX slot is a load to a nonzero register the ID slot reads
module hazard_match
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] ex_dest_i,
    input  logic             ex_ld_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic             usesrt_i,
    output logic             hit_o
);
    assign hit_o = ex_ld_i && ex_dest_i != REG_W'(ZERO_REG) &&
                   (ex_dest_i == rs_i || (usesrt_i && ex_dest_i == rt_i));
endmodule

// File: rtl/dual_issue_hazard_unit.sv
// dual_issue_hazard_unit: decides which slots of the ID bundle may enter EX each cycle.
//   clk, rst (sync, active-low), flush        : clock, reset, redirect kill
//   id_valid*/rs*/rt*/usesrt*/dest*/regwrite*/memread* : ID bundle fields
//   issue1/issue2 : slot enters EX; stall_if : hold PC and IF/ID
//   hold_slot2    : IF/ID keeps slot 2 only; bubble_ex : NOP into ID/EX for non-issued slot(s)
//   stall_cnt     : saturating count of stall/split cycles
module dual_issue_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = REG_W_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             id_valid1,
    input  logic             id_valid2,
    input  logic [REG_W-1:0] rs1_ID,
    input  logic [REG_W-1:0] rt1_ID,
    input  logic [REG_W-1:0] rs2_ID,
    input  logic [REG_W-1:0] rt2_ID,
    input  logic             usesrt1_ID,
    input  logic             usesrt2_ID,
    input  logic [REG_W-1:0] dest1_ID,
    input  logic [REG_W-1:0] dest2_ID,
    input  logic             regwrite1_ID,
    input  logic             regwrite2_ID,
    input  logic             memread1_ID,
    input  logic             memread2_ID,
    output logic             issue1,
    output logic             issue2,
    output logic             stall_if,
    output logic             hold_slot2,
    output logic             bubble_ex,
    output logic [CNT_W-1:0] stall_cnt
);
    state_t           state_q, state_d;
    logic [REG_W-1:0] ex_dest1_q, ex_dest2_q;
    logic             ex_ld1_q, ex_ld2_q;
    logic [CNT_W-1:0] cnt_q;
    logic             h11, h12, h21, h22, lu1, lu2, dep;

    hazard_match #(.REG_W(REG_W)) u_m11 (.ex_dest_i(ex_dest1_q), .ex_ld_i(ex_ld1_q), .rs_i(rs1_ID), .rt_i(rt1_ID), .usesrt_i(usesrt1_ID), .hit_o(h11));
    hazard_match #(.REG_W(REG_W)) u_m12 (.ex_dest_i(ex_dest2_q), .ex_ld_i(ex_ld2_q), .rs_i(rs1_ID), .rt_i(rt1_ID), .usesrt_i(usesrt1_ID), .hit_o(h12));
    hazard_match #(.REG_W(REG_W)) u_m21 (.ex_dest_i(ex_dest1_q), .ex_ld_i(ex_ld1_q), .rs_i(rs2_ID), .rt_i(rt2_ID), .usesrt_i(usesrt2_ID), .hit_o(h21));
    hazard_match #(.REG_W(REG_W)) u_m22 (.ex_dest_i(ex_dest2_q), .ex_ld_i(ex_ld2_q), .rs_i(rs2_ID), .rt_i(rt2_ID), .usesrt_i(usesrt2_ID), .hit_o(h22));

    // An invalid slot carries no real instruction, so it never causes a load-use stall.
    assign lu1 = id_valid1 && (h11 || h12);
    assign lu2 = id_valid2 && (h21 || h22);
    assign dep = id_valid1 && id_valid2 && regwrite1_ID && dest1_ID != REG_W'(ZERO_REG) &&
                 (dest1_ID == rs2_ID || (usesrt2_ID && dest1_ID == rt2_ID) ||
                  (regwrite2_ID && dest1_ID == dest2_ID));

    always_comb begin
        issue1     = 1'b0;
        issue2     = 1'b0;
        stall_if   = 1'b0;
        hold_slot2 = 1'b0;
        bubble_ex  = 1'b0;
        state_d    = state_q;
        if (!rst) begin
            state_d = PAIR;
        end else if (state_q == PAIR) begin
            if (flush) begin
                bubble_ex = 1'b1;
            end else if (lu1 || (lu2 && !dep)) begin
                bubble_ex = 1'b1;
                stall_if  = 1'b1;
            end else if (dep) begin
                issue1     = 1'b1;
                stall_if   = 1'b1;
                hold_slot2 = 1'b1;
                bubble_ex  = 1'b1;
                state_d    = HALF;
            end else begin
                issue1 = id_valid1;
                issue2 = id_valid2;
            end
        end else begin
            // Slot 1 already sits in EX, so any RAW on it is covered by forwarding.
            if (flush) begin
                bubble_ex = 1'b1;
                state_d   = PAIR;
            end else if (lu2) begin
                bubble_ex = 1'b1;
                stall_if  = 1'b1;
            end else begin
                issue2  = 1'b1;
                state_d = PAIR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= PAIR;
            ex_dest1_q <= '0;
            ex_dest2_q <= '0;
            ex_ld1_q   <= 1'b0;
            ex_ld2_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ex_dest1_q <= issue1 ? dest1_ID : '0;
            ex_dest2_q <= issue2 ? dest2_ID : '0;
            ex_ld1_q   <= issue1 && memread1_ID;
            ex_ld2_q   <= issue2 && memread2_ID;
            cnt_q      <= (stall_if && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        end
    end

    assign stall_cnt = rst ? cnt_q : '0;
endmodule

// File: tb/tb_dual_issue_hazard_unit.sv
// tb_dual_issue_hazard_unit: directed and random checks of the hazard unit against a rule-level model.
module tb_dual_issue_hazard_unit;
    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ut;
        logic [4:0] d;
        logic       w;
        logic       m;
    } ins_t;

    logic clk = 1'b0;
    logic rst, flush;
    logic id_valid1, id_valid2, usesrt1_ID, usesrt2_ID;
    logic regwrite1_ID, regwrite2_ID, memread1_ID, memread2_ID;
    logic [4:0] rs1_ID, rt1_ID, rs2_ID, rt2_ID, dest1_ID, dest2_ID;
    logic issue1, issue2, stall_if, hold_slot2, bubble_ex;
    logic [15:0] stall_cnt;
    logic s_issue1, s_issue2, s_stall_if, s_hold_slot2, s_bubble_ex;
    logic [1:0] s_stall_cnt;

    int total = 0;
    int bad = 0;

    bit         m_half;
    logic [4:0] m_dest[2];
    bit         m_ld[2];
    int         m_cnt;

    always #5 clk = ~clk;

    dual_issue_hazard_unit #(.REG_W(5), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .id_valid1(id_valid1), .id_valid2(id_valid2),
        .rs1_ID(rs1_ID), .rt1_ID(rt1_ID), .rs2_ID(rs2_ID), .rt2_ID(rt2_ID),
        .usesrt1_ID(usesrt1_ID), .usesrt2_ID(usesrt2_ID), .dest1_ID(dest1_ID), .dest2_ID(dest2_ID),
        .regwrite1_ID(regwrite1_ID), .regwrite2_ID(regwrite2_ID),
        .memread1_ID(memread1_ID), .memread2_ID(memread2_ID),
        .issue1(issue1), .issue2(issue2), .stall_if(stall_if), .hold_slot2(hold_slot2),
        .bubble_ex(bubble_ex), .stall_cnt(stall_cnt)
    );

    dual_issue_hazard_unit #(.REG_W(5), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .flush(flush), .id_valid1(id_valid1), .id_valid2(id_valid2),
        .rs1_ID(rs1_ID), .rt1_ID(rt1_ID), .rs2_ID(rs2_ID), .rt2_ID(rt2_ID),
        .usesrt1_ID(usesrt1_ID), .usesrt2_ID(usesrt2_ID), .dest1_ID(dest1_ID), .dest2_ID(dest2_ID),
        .regwrite1_ID(regwrite1_ID), .regwrite2_ID(regwrite2_ID),
        .memread1_ID(memread1_ID), .memread2_ID(memread2_ID),
        .issue1(s_issue1), .issue2(s_issue2), .stall_if(s_stall_if), .hold_slot2(s_hold_slot2),
        .bubble_ex(s_bubble_ex), .stall_cnt(s_stall_cnt)
    );

    function automatic ins_t r_op(input int d, input int s, input int t);
        r_op = '{v: 1'b1, rs: 5'(s), rt: 5'(t), ut: 1'b1, d: 5'(d), w: 1'b1, m: 1'b0};
    endfunction

    function automatic ins_t lw_op(input int d, input int s);
        lw_op = '{v: 1'b1, rs: 5'(s), rt: 5'd0, ut: 1'b0, d: 5'(d), w: 1'b1, m: 1'b1};
    endfunction

    function automatic ins_t rnd_op();
        ins_t x;
        x.v  = ($urandom % 8) != 0;
        x.rs = 5'($urandom % 4);
        x.rt = 5'($urandom % 4);
        x.ut = 1'($urandom);
        x.d  = 5'($urandom % 4);
        x.w  = 1'($urandom);
        x.m  = x.w && ($urandom % 2 == 0);
        return x;
    endfunction

    task automatic set_b(input ins_t a, input ins_t b);
        {id_valid1, rs1_ID, rt1_ID, usesrt1_ID, dest1_ID, regwrite1_ID, memread1_ID} = a;
        {id_valid2, rs2_ID, rt2_ID, usesrt2_ID, dest2_ID, regwrite2_ID, memread2_ID} = b;
    endtask

    task automatic chk(input string tag, input string sig, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s.%s got=%0d exp=%0d", tag, sig, got, exp);
        end
    endtask

    function automatic bit hits(input logic [4:0] rs, input logic [4:0] rt, input bit ut);
        hits = 1'b0;
        for (int e = 0; e < 2; e++)
            if (m_ld[e] && m_dest[e] != 0 && (m_dest[e] == rs || (ut && m_dest[e] == rt))) hits = 1'b1;
    endfunction

    task automatic tick(input string tag);
        bit lu1, lu2, dep, e1, e2, es, eh, eb, nh;
        #1;
        lu1 = id_valid1 && hits(rs1_ID, rt1_ID, usesrt1_ID);
        lu2 = id_valid2 && hits(rs2_ID, rt2_ID, usesrt2_ID);
        dep = id_valid1 && id_valid2 && regwrite1_ID && dest1_ID != 0 &&
              (dest1_ID == rs2_ID || (usesrt2_ID && dest1_ID == rt2_ID) || (regwrite2_ID && dest1_ID == dest2_ID));
        {e1, e2, es, eh, eb} = '0;
        nh = m_half;
        if (!rst) nh = 1'b0;
        else if (!m_half) begin
            if (flush) eb = 1'b1;
            else if (lu1 || (lu2 && !dep)) {eb, es} = 2'b11;
            else if (dep) {e1, es, eh, eb, nh} = 5'b11111;
            else {e1, e2} = {id_valid1, id_valid2};
        end else begin
            if (flush) {eb, nh} = 2'b10;
            else if (lu2) {eb, es} = 2'b11;
            else {e2, nh} = 2'b10;
        end
        chk(tag, "issue1", 32'(issue1), 32'(e1));
        chk(tag, "issue2", 32'(issue2), 32'(e2));
        chk(tag, "stall_if", 32'(stall_if), 32'(es));
        chk(tag, "hold_slot2", 32'(hold_slot2), 32'(eh));
        chk(tag, "bubble_ex", 32'(bubble_ex), 32'(eb));
        chk(tag, "stall_cnt", 32'(stall_cnt), rst ? 32'(m_cnt) : 32'd0);
        chk(tag, "sat_cnt", 32'(s_stall_cnt), rst ? 32'(m_cnt > 3 ? 3 : m_cnt) : 32'd0);
        @(posedge clk);
        if (!rst) begin
            m_half = 1'b0;
            m_dest = '{5'd0, 5'd0};
            m_ld   = '{1'b0, 1'b0};
            m_cnt  = 0;
        end else begin
            m_half    = nh;
            m_dest[0] = e1 ? dest1_ID : 5'd0;
            m_dest[1] = e2 ? dest2_ID : 5'd0;
            m_ld[0]   = e1 && memread1_ID;
            m_ld[1]   = e2 && memread2_ID;
            if (es && m_cnt < 65535) m_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        ins_t nop;
        nop = '0;
        rst = 1'b0;
        flush = 1'b0;
        m_half = 1'b0;
        m_dest = '{5'd0, 5'd0};
        m_ld = '{1'b0, 1'b0};
        m_cnt = 0;
        @(negedge clk);
        set_b(lw_op(8, 1), r_op(3, 2, 2));
        tick("reset0");
        tick("reset1");
        rst = 1'b1;
        tick("lw8");
        set_b(r_op(9, 8, 1), r_op(10, 2, 3));
        tick("lu_stall");
        tick("lu_go");
        set_b(nop, nop);
        tick("lu_cnt");
        set_b(r_op(5, 1, 2), r_op(6, 5, 3));
        tick("raw_split");
        tick("raw_half");
        set_b(r_op(0, 1, 2), r_op(4, 0, 0));
        tick("zero_dest");
        set_b(r_op(7, 1, 2), r_op(7, 3, 4));
        tick("waw_split");
        tick("waw_half");
        set_b(lw_op(10, 1), r_op(11, 10, 2));
        tick("fl_split");
        flush = 1'b1;
        tick("fl_half");
        flush = 1'b0;
        set_b(r_op(12, 10, 10), nop);
        tick("fl_after");
        set_b(r_op(5, 1, 2), r_op(6, 5, 3));
        tick("rst_split");
        rst = 1'b0;
        tick("rst_half");
        rst = 1'b1;
        set_b(r_op(1, 2, 3), r_op(4, 5, 6));
        tick("rst_pair");
        repeat (5) begin
            set_b(lw_op(8, 1), nop);
            tick("sat_lw");
            set_b(r_op(9, 8, 1), nop);
            tick("sat_stall");
            tick("sat_go");
        end
        repeat (400) begin
            rst = ($urandom % 50) != 0;
            flush = ($urandom % 10) == 0;
            set_b(rnd_op(), rnd_op());
            tick("rand");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
